// File: rtl/ascon_bdi_packer.sv
// Byte-to-word packer feeding the Ascon core BDI port.
// Collects up to NB bytes per word, then holds the word until the core takes it.
module ascon_bdi_packer #(
   parameter int CCW = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_type,
   input  logic              in_last,
   input  logic              in_eoi,
   output logic [CCW-1:0]    bdi,
   output logic [CCW/8-1:0]  bdi_valid,
   input  logic              bdi_ready,
   output logic [3:0]        bdi_type,
   output logic              bdi_eot,
   output logic              bdi_eoi,
   output logic              err
);

   localparam int NB = CCW / 8;
   localparam int IW = (NB > 4) ? 3 : 2;
   localparam logic [IW-1:0] IDX_MAX = IW'(NB - 1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CCW-1:0]  data_q, data_d;
   logic [NB-1:0]   mask_q, mask_d;
   logic [3:0]      type_q, type_d;
   logic            eot_q, eot_d;
   logic            eoi_q, eoi_d;
   logic            err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         idx_q   <= '0;
         data_q  <= '0;
         mask_q  <= '0;
         type_q  <= '0;
         eot_q   <= 1'b0;
         eoi_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         type_q  <= type_d;
         eot_q   <= eot_d;
         eoi_q   <= eoi_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      mask_d  = mask_q;
      type_d  = type_q;
      eot_d   = eot_q;
      eoi_d   = eoi_q;
      err_d   = err_q;
      unique case (state_q)
         FILL: begin
            if (in_valid) begin
               data_d[{idx_q, 3'b000} +: 8] = in_data;
               mask_d[idx_q] = 1'b1;
               // Type mismatch mid-word is flagged, but the word keeps its first type
               if (idx_q == '0)
                  type_d = in_type;
               else if (in_type != type_q)
                  err_d = 1'b1;
               if (idx_q == IDX_MAX || in_last) begin
                  state_d = HOLD;
                  eot_d   = in_last;
                  eoi_d   = in_last & in_eoi;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (bdi_ready) begin
               state_d = FILL;
               idx_d   = '0;
               data_d  = '0;
               mask_d  = '0;
               eot_d   = 1'b0;
               eoi_d   = 1'b0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   assign in_ready  = (state_q == FILL);
   assign bdi_valid = (state_q == HOLD) ? mask_q : '0;
   assign bdi       = data_q;
   assign bdi_type  = type_q;
   assign bdi_eot   = eot_q;
   assign bdi_eoi   = eoi_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ascon_bdi_packer.sv
// Scoreboard bench for ascon_bdi_packer at CCW=32.
// Stimulus pushes expected words; a monitor pops them on each word handshake.
module tb_ascon_bdi_packer;

   localparam logic [3:0] D_AD    = 4'h1;
   localparam logic [3:0] D_MSG   = 4'h4;
   localparam logic [3:0] D_TAG   = 4'h8;
   localparam logic [3:0] D_NONCE = 4'hD;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_type;
   logic        in_last;
   logic        in_eoi;
   logic [31:0] bdi;
   logic [3:0]  bdi_valid;
   logic        bdi_ready;
   logic [3:0]  bdi_type;
   logic        bdi_eot;
   logic        bdi_eoi;
   logic        err;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  mask;
      logic [3:0]  typ;
      logic        eot;
      logic        eoi;
   } word_t;

   word_t sb[$];
   int    n_vec = 0;
   int    n_bad = 0;

   ascon_bdi_packer #(.CCW(32)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_type(in_type), .in_last(in_last), .in_eoi(in_eoi),
      .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
      .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] m,
                       input logic [3:0] t, input logic eot,
                       input logic eoi);
      word_t w;
      w.data = d; w.mask = m; w.typ = t; w.eot = eot; w.eoi = eoi;
      sb.push_back(w);
   endtask

   // Monitor: every accepted word must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && bdi_valid != 4'b0 && bdi_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_word: got %h mask %b", bdi, bdi_valid);
         end else begin
            word_t w;
            w = sb.pop_front();
            chk("word_data", bdi, w.data);
            chk("word_mask", 32'(bdi_valid), 32'(w.mask));
            chk("word_type", 32'(bdi_type), 32'(w.typ));
            chk("word_eot", 32'(bdi_eot), 32'(w.eot));
            chk("word_eoi", 32'(bdi_eoi), 32'(w.eoi));
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic [3:0] t,
                       input logic last, input logic eoi);
      int n;
      in_data = d; in_type = t; in_last = last; in_eoi = eoi;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0; in_eoi = 1'b0;
   endtask

   task automatic accept();
      int n;
      bdi_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (bdi_valid == 4'b0 && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (bdi_valid == 4'b0) chk("accept_timeout", 32'(bdi_valid), 32'hF);
      @(posedge clk);
      #1;
      bdi_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_type = '0;
      in_last = 1'b0; in_eoi = 1'b0; bdi_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_bdi_valid", 32'(bdi_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;

      // Full AD word
      push(32'h04030201, 4'b1111, D_AD, 1'b1, 1'b0);
      send(8'h01, D_AD, 1'b0, 1'b1);
      send(8'h02, D_AD, 1'b0, 1'b0);
      send(8'h03, D_AD, 1'b0, 1'b0);
      send(8'h04, D_AD, 1'b1, 1'b0);
      @(negedge clk);
      chk("full_hold_in_ready", 32'(in_ready), 32'd0);
      chk("full_hold_mask", 32'(bdi_valid), 32'hF);
      @(negedge clk);
      chk("full_hold_in_ready2", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      accept();

      // Partial last word with eoi
      push(32'h0000BBAA, 4'b0011, D_MSG, 1'b1, 1'b1);
      send(8'hAA, D_MSG, 1'b0, 1'b0);
      send(8'hBB, D_MSG, 1'b1, 1'b1);
      accept();

      // Six bytes with backpressure on the first word
      push(32'h13121110, 4'b1111, D_MSG, 1'b0, 1'b0);
      push(32'h00001514, 4'b0011, D_MSG, 1'b1, 1'b0);
      send(8'h10, D_MSG, 1'b0, 1'b0);
      send(8'h11, D_MSG, 1'b0, 1'b0);
      send(8'h12, D_MSG, 1'b0, 1'b0);
      send(8'h13, D_MSG, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_data", bdi, 32'h13121110);
         chk("stall_mask", 32'(bdi_valid), 32'hF);
         chk("stall_eot", 32'(bdi_eot), 32'd0);
      end
      @(posedge clk); #1;
      accept();
      send(8'h14, D_MSG, 1'b0, 1'b0);
      send(8'h15, D_MSG, 1'b1, 1'b0);
      accept();

      // Type mismatch inside a word
      push(32'h00000201, 4'b0011, D_AD, 1'b1, 1'b0);
      send(8'h01, D_AD, 1'b0, 1'b0);
      send(8'h02, D_MSG, 1'b1, 1'b0);
      @(negedge clk);
      chk("mismatch_err", 32'(err), 32'd1);
      chk("mismatch_type", 32'(bdi_type), 32'(D_AD));
      @(posedge clk); #1;
      accept();
      @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      @(posedge clk); #1;

      // Reset while a word is held discards it; byte in reset cycle ignored
      send(8'h01, D_TAG, 1'b0, 1'b0);
      send(8'h02, D_TAG, 1'b0, 1'b0);
      send(8'h03, D_TAG, 1'b0, 1'b0);
      send(8'h04, D_TAG, 1'b1, 1'b0);
      @(negedge clk);
      chk("pre_rst_mask", 32'(bdi_valid), 32'hF);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_data = 8'h99; in_type = D_TAG; in_last = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_mask", 32'(bdi_valid), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      chk("rst_byte_ignored", 32'(bdi_valid), 32'd0);
      @(posedge clk); #1;
      push(32'h00000055, 4'b0001, D_MSG, 1'b1, 1'b0);
      send(8'h55, D_MSG, 1'b1, 1'b0);
      accept();

      // Single byte with bdi_ready tied high
      bdi_ready = 1'b1;
      push(32'h0000007F, 4'b0001, D_NONCE, 1'b1, 1'b0);
      send(8'h7F, D_NONCE, 1'b1, 1'b0);
      @(negedge clk);
      chk("single_presented", 32'(bdi_valid), 32'h1);
      chk("single_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("single_in_ready_back", 32'(in_ready), 32'd1);
      chk("single_mask_clear", 32'(bdi_valid), 32'd0);
      bdi_ready = 1'b0;

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
